// File: rtl/nlm_line_buf_ctrl.sv
// nlm_line_buf_ctrl
// -----------------------------------------------------------------------------
// Controller for two ping-pong line buffers. It turns a raster pixel stream
// into 3-pixel vertical columns {top, mid, cur} for a non-local-means window.
//
// The buffers are external single-port-address RAMs with a shared read/write
// address. Reads have 1 cycle of registered latency and read-before-write
// behaviour. A read and a write can hit the same address in one cycle: the
// read returns the line from two rows back (top) from buffer `sel`, and that
// location is then overwritten with the current pixel. Buffer ~sel holds the
// previous row (mid).
//
// Ports
//   clk                  single clock, all logic on the rising edge
//   rst_i                synchronous, active-high reset
//   line_len_i           line width minus 1, sampled with the sof pixel
//   pix_i / pix_vld_i    incoming pixel and qualifier (gaps allowed)
//   sof_i                start of frame, qualified by pix_vld_i
//   wraddr_o, rdaddr_o   line-buffer address (combinational)
//   wrdata_o             line-buffer write data (combinational)
//   wren_o[1:0]          per-buffer write enable (combinational)
//   rden_o               common read enable (combinational)
//   rddata0_i/rddata1_i  line-buffer read data, 1 cycle after rden_o
//   col_o                {top, mid, cur}, cur in the LSBs
//   col_vld_o            column valid
//   col_sof_o            first column of the frame
//   col_eol_o            last column of a line
//
// Build option
//   NLM_BORDER_REPLICATE_EN  when defined, rows 0 and 1 also produce
//                            columns with the missing rows replicated:
//                            row 0 -> {cur,cur,cur}, row 1 -> {mid,mid,cur}.
// -----------------------------------------------------------------------------
module nlm_line_buf_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     line_len_i,
  input  logic [DATA_WIDTH-1:0]     pix_i,
  input  logic                      pix_vld_i,
  input  logic                      sof_i,
  output logic [ADDR_WIDTH-1:0]     wraddr_o,
  output logic [ADDR_WIDTH-1:0]     rdaddr_o,
  output logic [DATA_WIDTH-1:0]     wrdata_o,
  output logic [1:0]                wren_o,
  output logic                      rden_o,
  input  logic [DATA_WIDTH-1:0]     rddata0_i,
  input  logic [DATA_WIDTH-1:0]     rddata1_i,
  output logic [3*DATA_WIDTH-1:0]   col_o,
  output logic                      col_vld_o,
  output logic                      col_sof_o,
  output logic                      col_eol_o
);

  // Frame/line state
  logic [ADDR_WIDTH-1:0] x;
  logic [1:0]            y;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] len;
  logic                  started;

  // Effective state for the pixel in flight: a sof pixel restarts the frame
  // at x = 0, y = 0 on buffer 0 with the freshly sampled line length,
  // regardless of what was in progress.
  logic                  acc;
  logic [ADDR_WIDTH-1:0] x_eff;
  logic [1:0]            y_eff;
  logic                  sel_eff;
  logic [ADDR_WIDTH-1:0] len_eff;
  logic                  eol_now;
  logic                  col_ok;

  // Stage 1 pipeline (aligned with the buffer read data)
  logic                  vld_p1;
  logic                  sof_p1;
  logic                  eol_p1;
  logic [DATA_WIDTH-1:0] cur_p1;
  logic                  sel_p1;
`ifdef NLM_BORDER_REPLICATE_EN
  logic [1:0]            y_p1;
`endif

  logic [DATA_WIDTH-1:0] top;
  logic [DATA_WIDTH-1:0] mid;

  // Stage 0: accept pixel, drive line-buffer ports
  // Pixels before the first sof after reset are dropped entirely.
  assign acc     = pix_vld_i & (started | sof_i);
  assign x_eff   = sof_i ? '0 : x;
  assign y_eff   = sof_i ? 2'd0 : y;
  assign sel_eff = sof_i ? 1'b0 : sel;
  assign len_eff = sof_i ? line_len_i : len;
  assign eol_now = (x_eff == len_eff);

`ifdef NLM_BORDER_REPLICATE_EN
  assign col_ok = acc;
`else
  assign col_ok = acc & (y_eff == 2'd2);
`endif

  assign wraddr_o = x_eff;
  assign rdaddr_o = x_eff;
  assign wrdata_o = pix_i;
  assign rden_o   = acc;
  assign wren_o   = acc ? (sel_eff ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      x       <= '0;
      y       <= 2'd0;
      sel     <= 1'b0;
      len     <= '0;
      started <= 1'b0;
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      eol_p1  <= 1'b0;
    end else begin
      vld_p1 <= col_ok;
      sof_p1 <= col_ok & sof_i;
      eol_p1 <= col_ok & eol_now;
      if (acc) begin
        started <= 1'b1;
        len     <= len_eff;
        if (eol_now) begin
          x   <= '0;
          sel <= ~sel_eff;
          y   <= (y_eff == 2'd2) ? 2'd2 : y_eff + 2'd1;
        end else begin
          x   <= x_eff + 1'b1;
          sel <= sel_eff;
          y   <= y_eff;
        end
      end
    end
  end

  // Data side of the stage-1 register: no reset, outputs are gated by vld_p1.
  always_ff @(posedge clk) begin
    if (acc) begin
      cur_p1 <= pix_i;
      sel_p1 <= sel_eff;
`ifdef NLM_BORDER_REPLICATE_EN
      y_p1   <= y_eff;
`endif
    end
  end

  // Stage 1: assemble column from read data
  assign top = sel_p1 ? rddata1_i : rddata0_i;
  assign mid = sel_p1 ? rddata0_i : rddata1_i;

  always_comb begin
    col_o = '0;
    if (vld_p1) begin
`ifdef NLM_BORDER_REPLICATE_EN
      if (y_p1 == 2'd0)
        col_o = {cur_p1, cur_p1, cur_p1};
      else if (y_p1 == 2'd1)
        col_o = {mid, mid, cur_p1};
      else
        col_o = {top, mid, cur_p1};
`else
      col_o = {top, mid, cur_p1};
`endif
    end
  end

  assign col_vld_o = vld_p1;
  assign col_sof_o = sof_p1;
  assign col_eol_o = eol_p1;

endmodule

// File: tb/tb_nlm_line_buf_ctrl.sv
// Testbench for nlm_line_buf_ctrl: line-buffer RAM models plus a
// line-history reference model and an expected-column scoreboard.
module tb_nlm_line_buf_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] line_len_i;
  logic [DW-1:0] pix_i;
  logic          pix_vld_i;
  logic          sof_i;
  logic [AW-1:0] wraddr_o, rdaddr_o;
  logic [DW-1:0] wrdata_o;
  logic [1:0]    wren_o;
  logic          rden_o;
  logic [DW-1:0] rddata0_i, rddata1_i;
  logic [3*DW-1:0] col_o;
  logic          col_vld_o, col_sof_o, col_eol_o;

  nlm_line_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_i(rst_i), .line_len_i(line_len_i), .pix_i(pix_i),
    .pix_vld_i(pix_vld_i), .sof_i(sof_i), .wraddr_o(wraddr_o),
    .rdaddr_o(rdaddr_o), .wrdata_o(wrdata_o), .wren_o(wren_o),
    .rden_o(rden_o), .rddata0_i(rddata0_i), .rddata1_i(rddata1_i),
    .col_o(col_o), .col_vld_o(col_vld_o), .col_sof_o(col_sof_o),
    .col_eol_o(col_eol_o)
  );

  always #5 clk = ~clk;

  // Line-buffer RAMs: registered read, read-before-write
  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  always @(posedge clk) begin
    if (rden_o) begin
      rddata0_i <= mem0[rdaddr_o];
      rddata1_i <= mem1[rdaddr_o];
    end
    if (wren_o[0]) mem0[wraddr_o] <= wrdata_o;
    if (wren_o[1]) mem1[wraddr_o] <= wrdata_o;
  end

  // Reference model: the last two complete rows and the row being built
  logic [DW-1:0] m1 [2**AW];
  logic [DW-1:0] m2 [2**AW];
  logic [DW-1:0] cl [2**AW];
  logic [AW-1:0] mx, mlen;
  int            my;
  logic          msel, mstarted;

  typedef struct {
    logic          vld;
    logic          sof;
    logic          eol;
    logic [3*DW-1:0] col;
  } exp_t;
  exp_t q[$];

  int passes = 0;
  int total  = 0;
  int ncol;
  logic [3*DW-1:0] firstcol, lastcol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mx = '0; my = 0; msel = 1'b0; mlen = '0; mstarted = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; pix_vld_i = 1'b0; sof_i = 1'b0; pix_i = '0; line_len_i = '0;
    @(posedge clk); #1;
    chk("rst_col_vld", col_vld_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_col_sof", col_sof_o, 0);
    chk("rst_col_eol", col_eol_o, 0);
    rst_i = 1'b0;
    model_clear();
    q.delete();
    ncol = 0; firstcol = '0; lastcol = '0;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] p, input logic [AW-1:0] l);
    exp_t e;
    logic acc, se, ok;
    logic [AW-1:0] xe, le;
    int ye;
    logic [DW-1:0] top, mid;
    pix_vld_i = v; sof_i = s; pix_i = p; line_len_i = l;
    #1;
    e.vld = 1'b0; e.sof = 1'b0; e.eol = 1'b0; e.col = '0;
    acc = v && (mstarted || s);
    if (acc) begin
      xe = s ? '0 : mx;
      ye = s ? 0 : my;
      se = s ? 1'b0 : msel;
      le = s ? l : mlen;
      chk("wren", wren_o, se ? 2'b10 : 2'b01);
      chk("rden", rden_o, 1);
      chk("addr", {wraddr_o, rdaddr_o}, {xe, xe});
      chk("wrdata", wrdata_o, p);
      top = m2[xe];
      mid = m1[xe];
`ifdef NLM_BORDER_REPLICATE_EN
      ok = 1'b1;
      if (ye == 0) begin top = p; mid = p; end
      else if (ye == 1) top = mid;
`else
      ok = (ye == 2);
`endif
      if (ok) begin
        e.vld = 1'b1; e.sof = s; e.eol = (xe == le); e.col = {top, mid, p};
      end
      cl[xe] = p;
      if (xe == le) begin
        for (int i = 0; i < 2**AW; i++) begin
          m2[i] = m1[i];
          m1[i] = cl[i];
        end
        mx = '0;
        my = (ye == 2) ? 2 : ye + 1;
        msel = ~se;
      end else begin
        mx = xe + 1'b1;
        my = ye;
        msel = se;
      end
      mlen = le;
      mstarted = 1'b1;
    end else begin
      chk("wren_idle", wren_o, 0);
      chk("rden_idle", rden_o, 0);
    end
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("col_vld", col_vld_o, e.vld);
    chk("col_sof", col_sof_o, e.sof);
    chk("col_eol", col_eol_o, e.eol);
    if (e.vld) chk("col", col_o, e.col);
    if (col_vld_o === 1'b1) begin
      if (ncol == 0) firstcol = col_o;
      lastcol = col_o;
      ncol++;
    end
  endtask

  initial begin
    rst_i = 1'b1; pix_vld_i = 1'b0; sof_i = 1'b0; pix_i = '0; line_len_i = '0;
    @(posedge clk);
    do_reset();

    // 12 back-to-back pixels, line length 4
    step(1, 1, 16'd1, 8'd3);
    for (int i = 2; i <= 12; i++) step(1, 0, DW'(i), 8'd3);
`ifdef NLM_BORDER_REPLICATE_EN
    chk("t1_ncol", ncol, 12);
    chk("t1_first", firstcol, 48'h0001_0001_0001);
`else
    chk("t1_ncol", ncol, 4);
    chk("t1_first", firstcol, 48'h0001_0005_0009);
`endif
    chk("t1_last", lastcol, 48'h0004_0008_000c);

    // Same stream with a gap after every pixel
    do_reset();
    step(1, 1, 16'd1, 8'd3);
    step(0, 0, DW'($urandom), 8'd3);
    for (int i = 2; i <= 12; i++) begin
      step(1, 0, DW'(i), 8'd3);
      step(0, 0, DW'($urandom), DW'($urandom) & 8'hff);
    end
    chk("t2_last", lastcol, 48'h0004_0008_000c);

    // sof in the middle of row 3 restarts the frame
    do_reset();
    step(1, 1, 16'd100, 8'd4);
    for (int i = 1; i < 17; i++) step(1, 0, DW'(100 + i), 8'd4);
    step(1, 1, 16'd200, 8'd4);
    for (int i = 1; i < 15; i++) begin
      step(1, 0, DW'(200 + i), 8'd4);
      if (i % 4 == 0) step(0, 0, 16'hdead, 8'd0);
    end
`ifdef NLM_BORDER_REPLICATE_EN
    chk("t3_ncol", ncol, 32);
`else
    chk("t3_ncol", ncol, 12);
    chk("t3_first", firstcol, 48'h0064_0069_006e);
`endif

    // Reset in the middle of row 2, then pixels without sof
    do_reset();
    step(1, 1, 16'd1, 8'd3);
    for (int i = 2; i <= 10; i++) step(1, 0, DW'(i), 8'd3);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, DW'(50 + i), 8'd3);
    chk("t4_ignored", ncol, 0);
    step(1, 1, 16'd1, 8'd3);
    for (int i = 2; i <= 12; i++) step(1, 0, DW'(i), 8'd3);
    chk("t4_last", lastcol, 48'h0004_0008_000c);

    // Maximum line length over three full lines
    do_reset();
    step(1, 1, 16'd1, 8'hff);
    for (int i = 1; i < 768; i++) step(1, 0, DW'(i * 7 + 1), 8'hff);
`ifdef NLM_BORDER_REPLICATE_EN
    chk("t5_ncol", ncol, 768);
`else
    chk("t5_ncol", ncol, 256);
`endif
    chk("t5_last", lastcol, {DW'(255 * 7 + 1), DW'(511 * 7 + 1), DW'(767 * 7 + 1)});

`ifdef NLM_BORDER_REPLICATE_EN
    // Border replication from row 0
    do_reset();
    step(1, 1, 16'd1, 8'd1);
    for (int i = 2; i <= 6; i++) step(1, 0, DW'(i), 8'd1);
    chk("t6_ncol", ncol, 6);
    chk("t6_first", firstcol, 48'h0001_0001_0001);
    chk("t6_last", lastcol, 48'h0002_0004_0006);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
